// File: rtl/dma_pcie_h2c_byp_pkg.sv
// Shared types, constants and the round-robin helper for the H2C bypass issuer.
`ifndef QID_WIDTH
`define QID_WIDTH 11
`endif

package dma_pcie_h2c_byp_pkg;

   localparam int QID_W   = `QID_WIDTH;
   localparam int NUM_CHN = 4;

   typedef struct packed {
      logic [63:0]      dsc;
      logic [QID_W-1:0] qid;
      logic             wbi;
      logic             wbi_chk;
      logic [15:0]      cidx;
      logic [15:0]      len;
      logic             last;
   } h2c_byp_dsc_t;

   typedef struct packed {
      logic       hit;
      logic [1:0] chn;
   } rr_pick_t;

   // First set bit of mask, searching upward from ptr with wrap.
   function automatic rr_pick_t rr_pick(input logic [NUM_CHN-1:0] mask,
                                        input logic [1:0]         ptr);
      rr_pick_t   r;
      logic [1:0] c;
      r = '0;
      for (int unsigned k = 0; k < NUM_CHN; k++) begin
         c = ptr + 2'(k);
         if (!r.hit && mask[c]) begin
            r.hit = 1'b1;
            r.chn = c;
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/dma_pcie_h2c_byp_in_if.sv
// H2C bypass-in interface between the issuer (master) and the DMA engine.
interface dma_pcie_h2c_byp_in_if;

   logic [63:0]                              dsc;
   logic [dma_pcie_h2c_byp_pkg::QID_W-1:0]   qid;
   logic                                     wbi;
   logic                                     wbi_chk;
   logic [15:0]                              cidx;
   logic [15:0]                              len;
   logic                                     last;
   logic [1:0]                               chn;
   logic                                     vld;
   logic                                     crdt;
   logic [1:0]                               crdt_chn;

   modport m (output dsc, qid, wbi, wbi_chk, cidx, len, last, chn, vld,
              input  crdt, crdt_chn);

   modport s (input  dsc, qid, wbi, wbi_chk, cidx, len, last, chn, vld,
              output crdt, crdt_chn);

endinterface

// File: rtl/dma_pcie_h2c_byp_fifo.sv
// Per-channel synchronous descriptor FIFO; pointers carry an extra wrap bit.
module dma_pcie_h2c_byp_fifo
   import dma_pcie_h2c_byp_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  h2c_byp_dsc_t             wdata,
   output h2c_byp_dsc_t             rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);

   h2c_byp_dsc_t  mem [DEPTH];
   logic [AW:0]   wptr;
   logic [AW:0]   rptr;

   always_ff @(posedge clk) begin
      if (rst) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wptr[AW-1:0]] <= wdata;
   end

   assign rdata = mem[rptr[AW-1:0]];
   assign count = wptr - rptr;
   assign empty = (wptr == rptr);
   assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/dma_pcie_h2c_byp_issue.sv
// Credit-gated H2C bypass descriptor issuer: per-channel FIFOs, round-robin
// arbitration with packet lock, two-stage registered issue to the engine.
module dma_pcie_h2c_byp_issue
   import dma_pcie_h2c_byp_pkg::*;
#(
   parameter int FIFO_DEPTH = 8,
   parameter int CRDT_W     = 8
) (
   input  logic                                        user_clk,
   input  logic                                        user_reset,
   input  logic                                        in_vld,
   output logic                                        in_rdy,
   input  logic [63:0]                                 in_dsc,
   input  logic [QID_W-1:0]                            in_qid,
   input  logic                                        in_wbi,
   input  logic                                        in_wbi_chk,
   input  logic [15:0]                                 in_cidx,
   input  logic [15:0]                                 in_len,
   input  logic                                        in_last,
   input  logic [1:0]                                  in_chn,
   dma_pcie_h2c_byp_in_if.m                            byp_out,
   output logic [NUM_CHN*CRDT_W-1:0]                   crdt_cnt,
   output logic [NUM_CHN*($clog2(FIFO_DEPTH)+1)-1:0]   fifo_cnt,
   output logic                                        err_crdt_ovf
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   logic [NUM_CHN-1:0]              full, empty, push, pop, ret, elig;
   logic [NUM_CHN-1:0][CW-1:0]      cnt;
   logic [NUM_CHN-1:0][CRDT_W-1:0]  crdt;
   h2c_byp_dsc_t                    head [NUM_CHN];
   h2c_byp_dsc_t                    wdata;

   logic [1:0]    rr_ptr, lock_chn, gnt;
   logic          locked, issue;
   rr_pick_t      pick;

   logic          s1_vld;
   h2c_byp_dsc_t  s1_dsc;
   logic [1:0]    s1_chn;

   assign wdata = '{dsc: in_dsc, qid: in_qid, wbi: in_wbi, wbi_chk: in_wbi_chk,
                    cidx: in_cidx, len: in_len, last: in_last};
   assign in_rdy = !user_reset && !full[in_chn];

   for (genvar c = 0; c < NUM_CHN; c++) begin : g_chn
      dma_pcie_h2c_byp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
         .clk   (user_clk),
         .rst   (user_reset),
         .push  (push[c]),
         .pop   (pop[c]),
         .wdata (wdata),
         .rdata (head[c]),
         .full  (full[c]),
         .empty (empty[c]),
         .count (cnt[c])
      );
   end

   always_comb begin
      push = '0;
      pop  = '0;
      ret  = '0;
      elig = '0;
      push[in_chn] = in_vld && in_rdy;
      ret[byp_out.crdt_chn] = byp_out.crdt;
      for (int unsigned c = 0; c < NUM_CHN; c++)
         elig[c] = !empty[c] && (crdt[c] != '0);

      // A held lock overrides round-robin; an ineligible locked channel idles.
      pick  = rr_pick(elig, rr_ptr);
      gnt   = pick.chn;
      issue = pick.hit;
      if (locked) begin
         gnt   = lock_chn;
         issue = elig[lock_chn];
      end
      pop[gnt] = issue;
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         crdt         <= '0;
         err_crdt_ovf <= 1'b0;
      end else begin
         for (int unsigned c = 0; c < NUM_CHN; c++) begin
            if (ret[c] && !pop[c]) begin
               if (crdt[c] == '1) err_crdt_ovf <= 1'b1;
               else               crdt[c] <= crdt[c] + 1'b1;
            end else if (pop[c] && !ret[c]) begin
               crdt[c] <= crdt[c] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         rr_ptr   <= '0;
         locked   <= 1'b0;
         lock_chn <= '0;
         s1_vld   <= 1'b0;
         s1_dsc   <= '0;
         s1_chn   <= '0;
      end else begin
         s1_vld <= issue;
         if (issue) begin
            s1_dsc   <= head[gnt];
            s1_chn   <= gnt;
            rr_ptr   <= gnt + 2'd1;
            locked   <= !head[gnt].last;
            lock_chn <= gnt;
         end
      end
   end

   always_ff @(posedge user_clk) begin
      if (user_reset) begin
         byp_out.vld     <= 1'b0;
         byp_out.dsc     <= '0;
         byp_out.qid     <= '0;
         byp_out.wbi     <= 1'b0;
         byp_out.wbi_chk <= 1'b0;
         byp_out.cidx    <= '0;
         byp_out.len     <= '0;
         byp_out.last    <= 1'b0;
         byp_out.chn     <= '0;
      end else begin
         byp_out.vld <= s1_vld;
         if (s1_vld) begin
            byp_out.dsc     <= s1_dsc.dsc;
            byp_out.qid     <= s1_dsc.qid;
            byp_out.wbi     <= s1_dsc.wbi;
            byp_out.wbi_chk <= s1_dsc.wbi_chk;
            byp_out.cidx    <= s1_dsc.cidx;
            byp_out.len     <= s1_dsc.len;
            byp_out.last    <= s1_dsc.last;
            byp_out.chn     <= s1_chn;
         end
      end
   end

   assign crdt_cnt = crdt;
   assign fifo_cnt = cnt;

endmodule

// File: tb/tb_dma_pcie_h2c_byp_issue.sv
// Directed bench for dma_pcie_h2c_byp_issue with a queue-based reference model.
module tb_dma_pcie_h2c_byp_issue
   import dma_pcie_h2c_byp_pkg::*;
();

   localparam int DEPTH  = 8;
   localparam int CRDT_W = 8;
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam int EXP_RR [10] = '{3, 3, 0, 1, 2, 3, 0, 1, 2, 3};
   localparam int EXP_LK [4]  = '{2, 2, 2, 0};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                            user_reset;
   logic                            in_vld, in_rdy;
   logic [63:0]                     in_dsc;
   logic [QID_W-1:0]                in_qid;
   logic                            in_wbi, in_wbi_chk, in_last;
   logic [15:0]                     in_cidx, in_len;
   logic [1:0]                      in_chn;
   logic [NUM_CHN*CRDT_W-1:0]       crdt_cnt;
   logic [NUM_CHN*CW-1:0]           fifo_cnt;
   logic                            err_crdt_ovf;

   dma_pcie_h2c_byp_in_if bif ();

   dma_pcie_h2c_byp_issue #(.FIFO_DEPTH(DEPTH), .CRDT_W(CRDT_W)) dut (
      .user_clk     (clk),
      .user_reset   (user_reset),
      .in_vld       (in_vld),
      .in_rdy       (in_rdy),
      .in_dsc       (in_dsc),
      .in_qid       (in_qid),
      .in_wbi       (in_wbi),
      .in_wbi_chk   (in_wbi_chk),
      .in_cidx      (in_cidx),
      .in_len       (in_len),
      .in_last      (in_last),
      .in_chn       (in_chn),
      .byp_out      (bif),
      .crdt_cnt     (crdt_cnt),
      .fifo_cnt     (fifo_cnt),
      .err_crdt_ovf (err_crdt_ovf)
   );

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
   endtask

   // Reference model: queues per channel, integer credits, decision delayed one edge.
   h2c_byp_dsc_t mq [NUM_CHN][$];
   int           mcred [NUM_CHN];
   int           mptr, mlock;
   bit           merr, model_ready = 1'b0;
   bit           pend_v;
   h2c_byp_dsc_t pend_d;
   int           pend_c;
   bit           exp_vld;
   h2c_byp_dsc_t exp_d;
   int           exp_chn;
   int           cyc = 0;

   function automatic bit m_elig(input int c);
      return mq[c].size() > 0 && mcred[c] > 0;
   endfunction

   always @(posedge clk) begin : model
      int g, v, pc;
      bit do_push;
      h2c_byp_dsc_t nd;
      cyc++;
      if (user_reset) begin
         for (int c = 0; c < NUM_CHN; c++) begin
            mq[c].delete();
            mcred[c] = 0;
         end
         mptr = 0; mlock = -1; merr = 0; pend_v = 0;
         exp_vld = 0; exp_d = '0; exp_chn = 0;
         model_ready = 1'b1;
      end else begin
         pc      = int'(in_chn);
         do_push = in_vld && (mq[pc].size() < DEPTH);
         nd      = '{dsc: in_dsc, qid: in_qid, wbi: in_wbi, wbi_chk: in_wbi_chk,
                     cidx: in_cidx, len: in_len, last: in_last};
         exp_vld = pend_v;
         if (pend_v) begin
            exp_d   = pend_d;
            exp_chn = pend_c;
         end
         g = -1;
         if (mlock >= 0) begin
            if (m_elig(mlock)) g = mlock;
         end else begin
            for (int k = 0; k < NUM_CHN; k++)
               if (g < 0 && m_elig((mptr + k) % NUM_CHN)) g = (mptr + k) % NUM_CHN;
         end
         pend_v = (g >= 0);
         if (g >= 0) begin
            pend_d = mq[g].pop_front();
            pend_c = g;
            mptr   = (g + 1) % NUM_CHN;
            mlock  = pend_d.last ? -1 : g;
         end
         for (int c = 0; c < NUM_CHN; c++) begin
            v = mcred[c] + ((bif.crdt && int'(bif.crdt_chn) == c) ? 1 : 0) - ((g == c) ? 1 : 0);
            if (v > (1 << CRDT_W) - 1) begin
               v    = (1 << CRDT_W) - 1;
               merr = 1'b1;
            end
            mcred[c] = v;
         end
         if (do_push) mq[pc].push_back(nd);
      end
   end

   int          seen_chn [$];
   bit          seen_last [$];
   logic [63:0] seen_dsc [$];
   int          seen_cyc [$];

   always @(negedge clk) begin : compare
      logic [NUM_CHN*CRDT_W-1:0] ec;
      logic [NUM_CHN*CW-1:0]     ef;
      if (model_ready) begin
         for (int c = 0; c < NUM_CHN; c++) begin
            ec[c*CRDT_W +: CRDT_W] = CRDT_W'(mcred[c]);
            ef[c*CW +: CW]         = CW'(mq[c].size());
         end
         chk("vld", 256'(bif.vld), 256'(exp_vld));
         chk("out_fields",
             256'({bif.dsc, bif.qid, bif.wbi, bif.wbi_chk, bif.cidx, bif.len, bif.last, bif.chn}),
             256'({exp_d, 2'(exp_chn)}));
         chk("in_rdy", 256'(in_rdy), 256'(!user_reset && mq[int'(in_chn)].size() < DEPTH));
         chk("crdt_cnt", 256'(crdt_cnt), 256'(ec));
         chk("fifo_cnt", 256'(fifo_cnt), 256'(ef));
         chk("err_crdt_ovf", 256'(err_crdt_ovf), 256'(merr));
         if (bif.vld) begin
            seen_chn.push_back(int'(bif.chn));
            seen_last.push_back(bif.last);
            seen_dsc.push_back(bif.dsc);
            seen_cyc.push_back(cyc);
         end
      end
   end

   function automatic int chn_at(input int i);
      return (i < seen_chn.size()) ? seen_chn[i] : 99;
   endfunction

   function automatic logic [63:0] dsc_at(input int i);
      return (i < seen_dsc.size()) ? seen_dsc[i] : '1;
   endfunction

   function automatic int cyc_at(input int i);
      return (i < seen_cyc.size()) ? seen_cyc[i] : -1000;
   endfunction

   task automatic clear_seen();
      seen_chn.delete(); seen_last.delete(); seen_dsc.delete(); seen_cyc.delete();
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      user_reset = 1'b1;
      step(1);
      user_reset = 1'b0;
   endtask

   task automatic push(input logic [1:0] ch, input logic last, input logic [63:0] d);
      in_vld = 1'b1; in_chn = ch; in_last = last; in_dsc = d;
      in_qid = d[32 +: QID_W]; in_cidx = d[15:0]; in_len = d[31:16];
      in_wbi = d[0]; in_wbi_chk = d[1];
      step(1);
      in_vld = 1'b0;
   endtask

   task automatic credit(input logic [1:0] ch);
      bif.crdt = 1'b1; bif.crdt_chn = ch;
      step(1);
      bif.crdt = 1'b0;
   endtask

   initial begin
      user_reset = 1'b1; in_vld = 1'b0; in_chn = '0; in_dsc = '0; in_qid = '0;
      in_wbi = 1'b0; in_wbi_chk = 1'b0; in_cidx = '0; in_len = '0; in_last = 1'b0;
      bif.crdt = 1'b0; bif.crdt_chn = '0;

      // Reset state
      step(2);
      chk("rst_in_rdy_low", 256'(in_rdy), 256'(0));
      chk("rst_vld_low", 256'(bif.vld), 256'(0));
      user_reset = 1'b0;
      #1;
      chk("rst_crdt_zero", 256'(crdt_cnt), 256'(0));
      chk("rst_fifo_zero", 256'(fifo_cnt), 256'(0));

      // No credit, then credit
      clear_seen();
      push(2'd1, 1'b1, 64'hA1);
      push(2'd1, 1'b1, 64'hA2);
      push(2'd1, 1'b1, 64'hA3);
      step(4);
      chk("nocrdt_fifo1", 256'(fifo_cnt[CW +: CW]), 256'(3));
      chk("nocrdt_no_issue", 256'(seen_chn.size()), 256'(0));
      credit(2'd1);
      credit(2'd1);
      step(5);
      chk("crdt_issue_count", 256'(seen_chn.size()), 256'(2));
      chk("crdt_issue0", 256'(dsc_at(0)), 256'(64'hA1));
      chk("crdt_issue1", 256'(dsc_at(1)), 256'(64'hA2));
      chk("crdt_cnt1_zero", 256'(crdt_cnt[CRDT_W +: CRDT_W]), 256'(0));
      chk("crdt_fifo1_one", 256'(fifo_cnt[CW +: CW]), 256'(1));

      // Round-robin released by a packet lock on channel 3
      do_reset();
      clear_seen();
      push(2'd3, 1'b0, 64'h300);
      credit(2'd3);
      step(3);
      push(2'd3, 1'b1, 64'h301);
      push(2'd3, 1'b1, 64'h302);
      push(2'd3, 1'b1, 64'h303);
      for (int c = 0; c < 3; c++) begin
         push(2'(c), 1'b1, 64'(c * 16));
         push(2'(c), 1'b1, 64'(c * 16 + 1));
      end
      for (int c = 0; c < 3; c++) repeat (4) credit(2'(c));
      step(3);
      chk("rr_locked_hold", 256'(seen_chn.size()), 256'(1));
      repeat (3) credit(2'd3);
      step(10);
      chk("rr_count", 256'(seen_chn.size()), 256'(10));
      for (int i = 0; i < 10; i++)
         chk($sformatf("rr_seq%0d", i), 256'(chn_at(i)), 256'(EXP_RR[i]));
      chk("rr_back_to_back", 256'(cyc_at(9) - cyc_at(2)), 256'(7));

      // Packet lock on channel 2 with channel 0 waiting
      do_reset();
      clear_seen();
      push(2'd2, 1'b0, 64'h20);
      push(2'd2, 1'b0, 64'h21);
      push(2'd2, 1'b1, 64'h22);
      push(2'd0, 1'b1, 64'h00);
      credit(2'd2);
      credit(2'd0);
      step(6);
      chk("lock_idle", 256'(seen_chn.size()), 256'(1));
      credit(2'd2);
      step(4);
      chk("lock_second", 256'(seen_chn.size()), 256'(2));
      credit(2'd2);
      step(5);
      chk("lock_count", 256'(seen_chn.size()), 256'(4));
      for (int i = 0; i < 4; i++)
         chk($sformatf("lock_seq%0d", i), 256'(chn_at(i)), 256'(EXP_LK[i]));

      // Full FIFO
      do_reset();
      for (int i = 0; i < 9; i++) push(2'd3, 1'b1, 64'(i + 64'h900));
      step(2);
      chk("full_fifo3", 256'(fifo_cnt[3*CW +: CW]), 256'(DEPTH));
      in_chn = 2'd3;
      #1;
      chk("full_rdy3_low", 256'(in_rdy), 256'(0));
      in_chn = 2'd0;
      #1;
      chk("full_rdy0_high", 256'(in_rdy), 256'(1));

      // Credit return coinciding with an issue, then saturation
      do_reset();
      push(2'd1, 1'b1, 64'h51);
      push(2'd1, 1'b1, 64'h52);
      bif.crdt = 1'b1; bif.crdt_chn = 2'd1;
      step(2);
      bif.crdt = 1'b0;
      chk("crdt_ret_and_issue", 256'(crdt_cnt[CRDT_W +: CRDT_W]), 256'(1));
      bif.crdt = 1'b1; bif.crdt_chn = 2'd2;
      step(255);
      chk("crdt_at_max", 256'(crdt_cnt[2*CRDT_W +: CRDT_W]), 256'(255));
      chk("ovf_not_yet", 256'(err_crdt_ovf), 256'(0));
      step(1);
      bif.crdt = 1'b0;
      chk("crdt_saturated", 256'(crdt_cnt[2*CRDT_W +: CRDT_W]), 256'(255));
      chk("ovf_set", 256'(err_crdt_ovf), 256'(1));
      step(3);
      chk("ovf_sticky", 256'(err_crdt_ovf), 256'(1));

      // Mid-packet reset, then 2-edge latency on a fresh channel
      do_reset();
      push(2'd0, 1'b0, 64'h70);
      push(2'd0, 1'b0, 64'h71);
      credit(2'd0);
      step(1);
      do_reset();
      chk("mid_rst_vld", 256'(bif.vld), 256'(0));
      chk("mid_rst_fifo", 256'(fifo_cnt), 256'(0));
      chk("mid_rst_crdt", 256'(crdt_cnt), 256'(0));
      credit(2'd1);
      push(2'd1, 1'b1, 64'hBEEF);
      chk("lat_edge0", 256'(bif.vld), 256'(0));
      step(1);
      chk("lat_edge1", 256'(bif.vld), 256'(0));
      step(1);
      chk("lat_edge2_vld", 256'(bif.vld), 256'(1));
      chk("lat_edge2_dsc", 256'(bif.dsc), 256'(64'hBEEF));
      step(3);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/dma_pcie_h2c_byp_issue.md
Name: dma_pcie_h2c_byp_issue

Overview:
- Credit-gated H2C bypass descriptor issuer.
- Accepts descriptors from user logic over a valid/ready port and buffers them in per-channel FIFOs.
- Issues them on the H2C bypass-in master port only when the DMA engine has returned credit for that channel.
- Sits directly upstream of the engine's H2C bypass input and is the sole driver of that interface.

Parameters:
- FIFO_DEPTH, 8, entries per channel FIFO; power of 2, ≥2.
- CRDT_W, 8, width of each per-channel credit counter.
- NUM_CHN, 4, channel count; fixed by the 2-bit chn field and not overridable.

Ports:
- user_clk  in  1  sole clock.
- user_reset  in  1  synchronous, active-high reset.
- in_vld  in  1  user descriptor valid.
- in_rdy  out  1  user descriptor ready.
- in_dsc  in  64  descriptor payload.
- in_qid  in  `QID_WIDTH  queue id.
- in_wbi  in  1  writeback/interrupt request.
- in_wbi_chk  in  1  writeback check.
- in_cidx  in  16  consumer index.
- in_len  in  16  byte length.
- in_last  in  1  last descriptor of packet.
- in_chn  in  2  target channel.
- byp_out  intf  —  dma_pcie_h2c_byp_in_if.m: dsc/qid/wbi/wbi_chk/cidx/len/last/chn/vld out; crdt/crdt_chn in.
- crdt_cnt  out  NUM_CHN*CRDT_W  current credit count per channel.
- fifo_cnt  out  NUM_CHN*($clog2(FIFO_DEPTH)+1)  FIFO occupancy per channel.
- err_crdt_ovf  out  1  sticky credit-overflow flag.

Behaviour:
- Reset: user_clk only, synchronous active-high user_reset. While user_reset is high:
  - All FIFOs are emptied, all credits are 0, the round-robin pointer is 0, the packet lock is cleared and err_crdt_ovf is 0.
  - byp_out.vld is 0 and all byp_out data fields are 0 on the first edge with reset high.
  - in_rdy is 0.
  - Reset asserted mid-packet discards all buffered descriptors with no partial issue.
- Input:
  - in_rdy = !full[in_chn].
  - A push happens when in_vld & in_rdy; the fields are written to FIFO[in_chn].
  - The data fields are don't-care when in_vld = 0.
- Credit:
  - An edge with byp_out.crdt = 1 adds 1 credit to channel crdt_chn.
  - An issue on channel c consumes 1 credit.
  - A return and an issue on the same channel in the same cycle leave the count unchanged.
  - A return to a counter already at 2^CRDT_W-1 saturates and sets err_crdt_ovf, which is sticky until reset.
- Eligibility: channel c is eligible when FIFO[c] is non-empty and credit[c] > 0, using registered counts.
- Arbitration:
  - Round-robin from (last granted + 1) mod 4.
  - At most one issue per cycle.
  - The pointer advances only on an issue.
- Packet lock:
  - Issuing a descriptor with last = 0 locks arbitration to that channel.
  - While locked, only that channel may issue; if it is ineligible, nothing issues.
  - Issuing last = 1 on the locked channel clears the lock.
- Output:
  - Registered. On an issue, byp_out.vld = 1 for exactly one cycle with the FIFO head fields and chn = granted channel; otherwise vld = 0 and the data fields hold.
  - There is no backpressure beyond credits, so the engine must accept every vld.
- Latency: a push accepted at edge N into an empty FIFO with credit > 0 and no competition gives byp_out.vld high in the cycle after edge N+2, i.e. 2 edges.
- Throughput: 1 descriptor/cycle sustained while credit is available.
- Simultaneous push and pop on the same FIFO: occupancy is unchanged; a full FIFO does not accept a push in the same cycle as a pop, because in_rdy uses the registered full flag.
- Wrap: FIFO pointers carry one extra bit for the full/empty distinction and wrap modulo 2*FIFO_DEPTH.

Decomposition:
- Package dma_pcie_h2c_byp_pkg:
  - typedef h2c_byp_dsc_t, packed struct {dsc, qid, wbi, wbi_chk, cidx, len, last}.
  - localparam NUM_CHN = 4.
  - Function rr_pick(eligible mask, pointer) returning {hit, chn}.
- Sub-module dma_pcie_h2c_byp_fifo: sync FIFO of h2c_byp_dsc_t, with push/pop/full/empty/count; instantiated 4×.

Test Plan:
- No credit, then credit: push 3 descriptors on chn 1 with credit 0 → vld stays 0 and fifo_cnt[1] = 3. Return 2 credits on chn 1 → exactly 2 vld pulses in push order, crdt_cnt[1] = 0, fifo_cnt[1] = 1.
- Round-robin: all channels hold 2 descriptors and 4 credits each → issue order chn 0,1,2,3,0,1,2,3 on consecutive cycles.
- Packet lock: chn 2 holds last = 0,0,1 with 1 credit, chn 0 holds 1 descriptor with credit → issue chn2(last=0), then idle while chn 0 stays eligible. Return 1 credit on chn 2 → chn2(last=0) issues, lock holds. Return 1 more credit on chn 2 → chn2(last=1) issues, then chn 0.
- Full FIFO: push 8 descriptors on chn 3 with credit 0 → in_rdy low when in_chn = 3 and high when in_chn = 0; the 9th chn 3 push is not accepted.
- Credit edge cases: credit return on chn 1 in the same cycle as an issue on chn 1 → crdt_cnt[1] unchanged. Return 256 credits on a chn with CRDT_W = 8 → count 255 and err_crdt_ovf = 1.
- Mid-packet reset: user_reset pulsed for 1 cycle mid-packet → next cycle vld = 0, fifo_cnt = 0, crdt_cnt = 0, lock cleared. A new descriptor plus 1 credit then issues with 2-cycle latency.
